spi_reg_master: RTL and testbench



---
 rtl/spi_reg_pkg.sv | 24 ++
 rtl/spi_tick_gen.sv | 35 +++
 rtl/spi_reg_master.sv | 144 ++++++++++++++
 tb/tb_spi_reg_master.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_reg_pkg
// Brief   : Shared types and constants for the SPI register-access initiator
// Revision: 1.0
// ============================================================================
package spi_reg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    localparam logic CMD_READ   = 1'b1;
    localparam logic CMD_WRITE  = 1'b0;
    localparam int   FRAME_BITS = 16;
    localparam int   DATA_BITS  = 8;

endpackage
`default_nettype wire

// File: rtl/spi_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : spi_tick_gen
// Brief   : Half-period divider producing one tick every DIV clk cycles
// Revision: 1.0
// ============================================================================
module spi_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int                 c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Clearing on frame start keeps every frame phase-aligned to the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_LAST) && !clear;

endmodule
`default_nettype wire

// File: rtl/spi_reg_master.sv
`default_nettype none
// ============================================================================
// Module  : spi_reg_master
// Brief   : SPI register-access initiator, one {rw,addr,data} CPOL=0 frame
// Revision: 1.0
// ============================================================================
module spi_reg_master
    import spi_reg_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rdata,
    output logic              sclk,
    output logic              mosi,
    output logic              cs,
    input  logic              miso
);

    localparam int                 c_FRAME_W  = 1 + ADDR_W + DATA_BITS;
    localparam int                 c_BIT_W    = $clog2(c_FRAME_W);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(c_FRAME_W - 1);
    localparam logic [c_BIT_W-1:0] c_RX_FIRST = c_BIT_W'(c_FRAME_W - DATA_BITS);

    state_t                 r_state;
    logic [c_FRAME_W-1:0]   r_shift;
    logic [c_BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0]   r_rx;
    logic                   r_rw;

    logic                   w_tick;
    logic                   w_clear;
    logic [c_FRAME_W-1:0]   w_frame;

    assign w_clear = start && (r_state == IDLE);
    assign w_frame = {rw, addr, (rw == CMD_READ) ? {DATA_BITS{1'b0}} : wdata};

    spi_tick_gen #(
        .DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_rx      <= '0;
            r_rw      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            cs        <= 1'b1;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift   <= w_frame;
                        r_rw      <= rw;
                        r_bit_cnt <= '0;
                        cs        <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        sclk    <= 1'b1;
                        mosi    <= r_shift[c_FRAME_W-1];
                        r_shift <= {r_shift[c_FRAME_W-2:0], 1'b0};
                        r_state <= HI;
                    end
                end
                HI: begin
                    if (w_tick) begin
                        sclk <= 1'b0;
                        if (r_bit_cnt >= c_RX_FIRST) begin
                            r_rx <= {r_rx[DATA_BITS-2:0], miso};
                        end
                        r_state <= LO;
                    end
                end
                LO: begin
                    if (w_tick) begin
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_state <= HOLD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            sclk      <= 1'b1;
                            mosi      <= r_shift[c_FRAME_W-1];
                            r_shift   <= {r_shift[c_FRAME_W-2:0], 1'b0};
                            r_state   <= HI;
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        cs      <= 1'b1;
                        mosi    <= 1'b0;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (w_tick) begin
                        done <= 1'b1;
                        if (r_rw == CMD_READ) begin
                            rdata <= r_rx;
                        end
                        // A request pending at frame end chains straight into
                        // the next frame so cs stays high for just the gap.
                        if (start) begin
                            r_shift   <= w_frame;
                            r_rw      <= rw;
                            r_bit_cnt <= '0;
                            cs        <= 1'b0;
                            r_state   <= SETUP;
                        end else begin
                            busy    <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_reg_master
// Brief   : Randomised self-checking bench with an SPI slave and frame model
// Revision: 1.0
// ============================================================================
module tb_spi_reg_master;
    import spi_reg_pkg::*;

    typedef struct packed {
        logic [15:0] bits;
        logic [7:0]  nrise;
        logic [7:0]  nfall;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_n_s = '0;
    logic [1:0]      start_s = '0;
    logic [1:0]      rw_s    = '0;
    logic [1:0]      miso_s  = '0;
    logic [1:0][6:0] addr_s  = '0;
    logic [1:0][7:0] wdata_s = '0;
    logic [1:0]      busy_s, done_s, sclk_s, mosi_s, cs_s;
    logic [1:0][7:0] rdata_s;

    // Instance 0 runs at CLK_DIV=2, instance 1 at CLK_DIV=1.
    spi_reg_master #(.CLK_DIV(2), .ADDR_W(7)) u_dut_a (
        .clk(clk), .rst_n(rst_n_s[0]), .start(start_s[0]), .rw(rw_s[0]),
        .addr(addr_s[0]), .wdata(wdata_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .rdata(rdata_s[0]), .sclk(sclk_s[0]), .mosi(mosi_s[0]), .cs(cs_s[0]),
        .miso(miso_s[0])
    );

    spi_reg_master #(.CLK_DIV(1), .ADDR_W(7)) u_dut_b (
        .clk(clk), .rst_n(rst_n_s[1]), .start(start_s[1]), .rw(rw_s[1]),
        .addr(addr_s[1]), .wdata(wdata_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .rdata(rdata_s[1]), .sclk(sclk_s[1]), .mosi(mosi_s[1]), .cs(cs_s[1]),
        .miso(miso_s[1])
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- slave model / bus monitor ----------------
    logic [1:0] p_cs, p_sclk, p_mosi;
    int         rises[2], falls[2], last_rise[2], cs_rise_t[2], last_gap[2];
    int         cs_falls[2], dones[2], viol[2];
    logic [15:0] cap[2];
    logic [7:0]  cur_sb[2];
    logic [7:0]  sb_q0[$], sb_q1[$];
    frame_t      fr_q0[$], fr_q1[$];

    initial begin
        frame_t f;
        p_cs   = 2'b11;
        p_sclk = '0;
        p_mosi = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (p_cs[i] && !cs_s[i]) begin
                    rises[i]    = 0;
                    falls[i]    = 0;
                    cap[i]      = '0;
                    cs_falls[i] = cs_falls[i] + 1;
                    last_gap[i] = cyc - cs_rise_t[i];
                    cur_sb[i]   = 8'($urandom);
                    if (i == 0 && sb_q0.size() > 0) cur_sb[i] = sb_q0.pop_front();
                    if (i == 1 && sb_q1.size() > 0) cur_sb[i] = sb_q1.pop_front();
                end else if (!p_cs[i] && cs_s[i]) begin
                    f.bits  = cap[i];
                    f.nrise = 8'(rises[i]);
                    f.nfall = 8'(falls[i]);
                    if (i == 0) fr_q0.push_back(f);
                    else        fr_q1.push_back(f);
                    cs_rise_t[i] = cyc;
                end else if (!cs_s[i]) begin
                    if (!p_sclk[i] && sclk_s[i]) begin
                        rises[i] = rises[i] + 1;
                        if (rises[i] > 1 && (cyc - last_rise[i]) != 2 * div_of(i)) viol[i] = viol[i] + 1;
                        last_rise[i] = cyc;
                        if (rises[i] > FRAME_BITS - DATA_BITS)
                            miso_s[i] = cur_sb[i][FRAME_BITS - rises[i]];
                        else
                            miso_s[i] = 1'($urandom_range(1));
                    end else if (mosi_s[i] != p_mosi[i]) begin
                        viol[i] = viol[i] + 1;
                    end
                    if (p_sclk[i] && !sclk_s[i]) begin
                        falls[i] = falls[i] + 1;
                        cap[i]   = {cap[i][14:0], mosi_s[i]};
                    end
                end else if (sclk_s[i] != p_sclk[i]) begin
                    viol[i] = viol[i] + 1;
                end
                if (done_s[i]) dones[i] = dones[i] + 1;
            end
            p_cs   = cs_s;
            p_sclk = sclk_s;
            p_mosi = mosi_s;
        end
    end

    // ---------------- reference model state ----------------
    logic [7:0] model_rd[2];
    int         exp_dones[2];

    task automatic push_sb(input int i, input logic [7:0] sb);
        if (i == 0) sb_q0.push_back(sb);
        else        sb_q1.push_back(sb);
    endtask

    task automatic pop_frame(input int i, output frame_t f, output int sz);
        f  = '0;
        sz = (i == 0) ? fr_q0.size() : fr_q1.size();
        if (sz > 0) begin
            if (i == 0) f = fr_q0.pop_front();
            else        f = fr_q1.pop_front();
        end
    endtask

    task automatic check_frame(input int i, input logic r, input logic [6:0] a, input logic [7:0] w);
        frame_t f;
        int     sz;
        pop_frame(i, f, sz);
        chk("frame_cnt", sz, 1);
        chk("frame_bits", f.bits, {r, a, (r == CMD_READ) ? 8'h00 : w});
        chk("frame_rise", f.nrise, FRAME_BITS);
        chk("frame_fall", f.nfall, FRAME_BITS);
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (busy_s[i] && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy_s[i], 1'b0);
    endtask

    task automatic wait_done(input int i, output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_s[i] && n < 300);
        chk("done_seen", done_s[i], 1'b1);
        t = cyc;
    endtask

    task automatic wait_rises(input int i, input int target);
        int n = 0;
        while (rises[i] != target && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("bit_reached", rises[i], target);
    endtask

    task automatic launch(input int i, input logic r, input logic [6:0] a,
                          input logic [7:0] w, output int t_acc);
        wait_idle(i);
        rw_s[i]    = r;
        addr_s[i]  = a;
        wdata_s[i] = w;
        start_s[i] = 1'b1;
        @(negedge clk);
        t_acc      = cyc;
        start_s[i] = 1'b0;
        chk("busy_after_start", busy_s[i], 1'b1);
    endtask

    task automatic send(input int i, input logic r, input logic [6:0] a,
                        input logic [7:0] w, input logic [7:0] sb);
        int t_acc, t_done;
        push_sb(i, sb);
        launch(i, r, a, w, t_acc);
        wait_done(i, t_done);
        exp_dones[i]++;
        chk("latency", t_done - t_acc, 35 * div_of(i));
        if (r == CMD_READ) model_rd[i] = sb;
        chk("rdata", rdata_s[i], model_rd[i]);
        check_frame(i, r, a, w);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int     t_acc, t1, t2, dn0, cf0;
        frame_t f;
        int     sz;

        model_rd  = '{8'h00, 8'h00};
        exp_dones = '{0, 0};
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_cs", cs_s[i], 1'b1);
            chk("rst_sclk", sclk_s[i], 1'b0);
            chk("rst_mosi", mosi_s[i], 1'b0);
            chk("rst_busy", busy_s[i], 1'b0);
            chk("rst_done", done_s[i], 1'b0);
            chk("rst_rdata", rdata_s[i], 8'h00);
        end
        rst_n_s = 2'b11;
        @(negedge clk);

        // Directed write then read.
        send(0, CMD_WRITE, 7'h02, 8'hA5, 8'h3C);
        send(0, CMD_READ,  7'h00, 8'h5B, 8'h96);

        // Second start mid-frame with different inputs must be ignored.
        push_sb(0, 8'h5A);
        dn0 = dones[0];
        launch(0, CMD_READ, 7'h11, 8'h00, t_acc);
        wait_rises(0, 6);
        rw_s[0] = CMD_WRITE; addr_s[0] = 7'h55; wdata_s[0] = 8'hFF; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        chk("mid_cs_low", cs_s[0], 1'b0);
        wait_done(0, t1);
        exp_dones[0]++;
        chk("mid_latency", t1 - t_acc, 70);
        model_rd[0] = 8'h5A;
        chk("mid_rdata", rdata_s[0], model_rd[0]);
        check_frame(0, CMD_READ, 7'h11, 8'h00);
        cf0 = cs_falls[0];
        repeat (80) @(negedge clk);
        chk("mid_no_refire", cs_falls[0], cf0);
        chk("mid_one_done", dones[0] - dn0, 1);

        // Reset during bit 10.
        push_sb(0, 8'h44);
        launch(0, CMD_WRITE, 7'h2A, 8'hC3, t_acc);
        wait_rises(0, 11);
        dn0 = dones[0];
        #2 rst_n_s[0] = 1'b0;
        #1;
        chk("abort_cs", cs_s[0], 1'b1);
        chk("abort_sclk", sclk_s[0], 1'b0);
        chk("abort_busy", busy_s[0], 1'b0);
        chk("abort_done", done_s[0], 1'b0);
        chk("abort_rdata", rdata_s[0], 8'h00);
        model_rd[0] = 8'h00;
        @(negedge clk);
        rst_n_s[0] = 1'b1;
        @(negedge clk);
        pop_frame(0, f, sz);
        chk("abort_frame_cnt", sz, 1);
        chk("abort_rises", f.nrise, 11);
        repeat (80) @(negedge clk);
        chk("abort_no_done", dones[0], dn0);
        send(0, CMD_READ, 7'h2A, 8'h00, 8'hE7);

        // Back-to-back reads with start held high.
        push_sb(0, 8'h01);
        push_sb(0, 8'h03);
        wait_idle(0);
        rw_s[0] = CMD_READ; addr_s[0] = 7'h01; wdata_s[0] = 8'h00; start_s[0] = 1'b1;
        @(negedge clk);
        t_acc = cyc;
        repeat (10) @(negedge clk);
        addr_s[0] = 7'h03;
        wait_done(0, t1);
        start_s[0] = 1'b0;
        exp_dones[0] += 2;
        chk("b2b_lat1", t1 - t_acc, 70);
        chk("b2b_rd1", rdata_s[0], 8'h01);
        chk("b2b_chained", busy_s[0], 1'b1);
        check_frame(0, CMD_READ, 7'h01, 8'h00);
        wait_done(0, t2);
        chk("b2b_lat2", t2 - t1, 70);
        chk("b2b_rd2", rdata_s[0], 8'h03);
        chk("b2b_cs_gap", last_gap[0], 2);
        check_frame(0, CMD_READ, 7'h03, 8'h00);
        model_rd[0] = 8'h03;

        // CLK_DIV=1 corner.
        send(1, CMD_WRITE, 7'h7F, 8'hFF, 8'h00);
        send(1, CMD_READ,  7'h40, 8'h12, 8'hC9);

        // Randomised traffic on both instances.
        for (int k = 0; k < 10; k++) begin
            send(k % 2, 1'($urandom_range(1)), 7'($urandom), 8'($urandom), 8'($urandom));
        end

        repeat (5) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("bus_rules", viol[i], 0);
            chk("done_total", dones[i], exp_dones[i]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
